// File: rtl/rl_cell_alloc.sv
// rl_cell_alloc: free-list cell allocator with self-initialising circular id FIFO; optional stats via RL_CELL_ALLOC_STATS_EN, cell size default via RL_CELL_SIZE
`ifndef RL_CELL_SIZE
`define RL_CELL_SIZE 2048
`endif
module rl_cell_alloc #(
  parameter int CELL_ID_WIDTH = 16,
  parameter int LEN_WIDTH = 16,
  parameter int NUM_CELLS = 1024,
  parameter int unsigned CELL_BYTES = `RL_CELL_SIZE,
  parameter int INTENSE_THRESH = 16,
  parameter int CNT_WIDTH = $clog2(NUM_CELLS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_mem_req,
  input  logic [LEN_WIDTH-1:0]     alloc_mem_size,
  output logic [CELL_ID_WIDTH-1:0] alloc_cell_id,
  output logic                     alloc_mem_success,
  output logic                     alloc_mem_intense,
  input  logic [CELL_ID_WIDTH-1:0] free_cell_id,
  input  logic                     free_valid,
  output logic                     free_ready,
  output logic [CNT_WIDTH-1:0]     free_count,
  output logic [31:0]              stat_alloc_cnt,
  output logic [31:0]              stat_fail_cnt,
  output logic [31:0]              stat_free_err,
  output logic [CNT_WIDTH-1:0]     stat_min_free
);
  localparam int PW = NUM_CELLS > 1 ? $clog2(NUM_CELLS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_CELLS - 1);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(NUM_CELLS);
  localparam logic [CNT_WIDTH-1:0] THR = CNT_WIDTH'(INTENSE_THRESH);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, init_idx_q, init_idx_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CELL_ID_WIDTH-1:0] mem_q [NUM_CELLS];
  logic run, grant, accept, mem_we;
  logic [PW-1:0] mem_waddr;
  logic [CELL_ID_WIDTH-1:0] mem_wdata;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction
  // alloc/free handshake outputs, all combinational from registered state
  always_comb begin
    run = state_q == S_RUN;
    grant = run && alloc_mem_req && count_q != '0 && 32'(alloc_mem_size) <= CELL_BYTES;
    free_ready = run && count_q != FULL;
    accept = free_valid && free_ready;
    alloc_mem_success = grant;
    alloc_mem_intense = !run || count_q <= THR;
    alloc_cell_id = (run && count_q != '0) ? mem_q[rd_ptr_q] : '0;
    free_count = count_q;
  end
  // next state: INIT fills ids 0..N-1 in order, RUN moves pointers on grant/accept
  always_comb begin
    state_d = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    init_idx_d = init_idx_q;
    count_d = count_q;
    mem_we = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = free_cell_id;
    if (!run) begin
      mem_we = 1'b1;
      mem_waddr = init_idx_q;
      mem_wdata = CELL_ID_WIDTH'(init_idx_q);
      init_idx_d = inc(init_idx_q);
      count_d = count_q + 1'b1;
      state_d = init_idx_q == LAST ? S_RUN : S_INIT;
    end else begin
      mem_we = accept;
      rd_ptr_d = grant ? inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = accept ? inc(wr_ptr_q) : wr_ptr_q;
      count_d = (accept && !grant) ? count_q + 1'b1 : (grant && !accept) ? count_q - 1'b1 : count_q;
    end
  end
  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      init_idx_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      init_idx_q <= init_idx_d;
      count_q <= count_d;
    end
  end
  // free-list storage, contents rebuilt by INIT so no reset needed
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
  end
`ifdef RL_CELL_ALLOC_STATS_EN
  logic [31:0] alloc_cnt_q, alloc_cnt_d, fail_cnt_q, fail_cnt_d, free_err_q, free_err_d;
  logic [CNT_WIDTH-1:0] min_free_q, min_free_d;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction
  // saturating event counters and free-count low watermark
  always_comb begin
    alloc_cnt_d = sat_inc(alloc_cnt_q, grant);
    fail_cnt_d = sat_inc(fail_cnt_q, run && alloc_mem_req && !grant);
    free_err_d = sat_inc(free_err_q, run && free_valid && count_q == FULL);
    min_free_d = (!run && state_d == S_RUN) ? FULL : (run && count_q < min_free_q) ? count_q : min_free_q;
  end
  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_cnt_q <= '0;
      fail_cnt_q <= '0;
      free_err_q <= '0;
      min_free_q <= '0;
    end else begin
      alloc_cnt_q <= alloc_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      free_err_q <= free_err_d;
      min_free_q <= min_free_d;
    end
  end
  assign stat_alloc_cnt = alloc_cnt_q;
  assign stat_fail_cnt = fail_cnt_q;
  assign stat_free_err = free_err_q;
  assign stat_min_free = min_free_q;
`else
  assign stat_alloc_cnt = '0;
  assign stat_fail_cnt = '0;
  assign stat_free_err = '0;
  assign stat_min_free = '0;
`endif
endmodule

// File: tb/tb_rl_cell_alloc.sv
// tb_rl_cell_alloc: directed table-driven bench for rl_cell_alloc with 8 cells
module tb_rl_cell_alloc;
`ifdef RL_CELL_ALLOC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic fv = 1'b0;
  logic [15:0] size = '0;
  logic [15:0] fid = '0;
  logic [15:0] cell_id;
  logic success, intense, ready;
  logic [3:0] count, min_free;
  logic [31:0] alloc_cnt, fail_cnt, free_err;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  rl_cell_alloc #(
    .CELL_ID_WIDTH(16), .LEN_WIDTH(16), .NUM_CELLS(8), .CELL_BYTES(2048), .INTENSE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .alloc_mem_req(req), .alloc_mem_size(size),
    .alloc_cell_id(cell_id), .alloc_mem_success(success), .alloc_mem_intense(intense),
    .free_cell_id(fid), .free_valid(fv), .free_ready(ready), .free_count(count),
    .stat_alloc_cnt(alloc_cnt), .stat_fail_cnt(fail_cnt), .stat_free_err(free_err),
    .stat_min_free(min_free)
  );
  typedef struct {
    bit restart;
    bit req;
    logic [15:0] size;
    bit fv;
    logic [15:0] fid;
    bit succ;
    logic [15:0] id;
    bit inten;
    bit rdy;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(bit restart, bit rq, int sz, bit v, int f, bit s, int id, bit it, bit rd, int c);
    vec_t r;
    r.restart = restart; r.req = rq; r.size = 16'(sz); r.fv = v; r.fid = 16'(f);
    r.succ = s; r.id = 16'(id); r.inten = it; r.rdy = rd; r.cnt = 4'(c);
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_stats(input string tag, input int a, input int f, input int e, input int m);
    check({tag, " stat_alloc_cnt"}, alloc_cnt, STATS ? 32'(a) : 32'd0);
    check({tag, " stat_fail_cnt"}, fail_cnt, STATS ? 32'(f) : 32'd0);
    check({tag, " stat_free_err"}, free_err, STATS ? 32'(e) : 32'd0);
    check({tag, " stat_min_free"}, 32'(min_free), STATS ? 32'(m) : 32'd0);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; req = 1'b0; fv = 1'b0; size = '0; fid = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].restart) begin
        do_reset;
        repeat (8) tick;
      end
      req = tbl[i].req; size = tbl[i].size; fv = tbl[i].fv; fid = tbl[i].fid;
      @(negedge clk);
      check($sformatf("row%0d success", i), 32'(success), 32'(tbl[i].succ));
      check($sformatf("row%0d cell_id", i), 32'(cell_id), 32'(tbl[i].id));
      check($sformatf("row%0d intense", i), 32'(intense), 32'(tbl[i].inten));
      check($sformatf("row%0d free_ready", i), 32'(ready), 32'(tbl[i].rdy));
      check($sformatf("row%0d free_count", i), 32'(count), 32'(tbl[i].cnt));
      tick;
    end
    req = 1'b0; fv = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 8; k++) tbl.push_back(mk(k == 0, 1, 2048, 0, 0, 1, k, (8 - k) <= 2, k != 0, 8 - k));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 2048, 0, 0, 1, 0, 0, 0, 8));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 1, 1, 0, 1, 7));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 1, 2, 0, 1, 6));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 1, 3, 0, 1, 5));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 1, 4, 0, 1, 4));
    tbl.push_back(mk(0, 1, 2048, 1, 1, 1, 5, 0, 1, 3));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 1, 6, 0, 1, 3));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 1, 7, 1, 1, 2));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 2048, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 4, 1, 1, 1));
    // reset state with a request held high
    req = 1'b1; size = 16'd16;
    tick;
    @(negedge clk);
    check("reset success", 32'(success), 0);
    check("reset free_ready", 32'(ready), 0);
    check("reset intense", 32'(intense), 1);
    check("reset free_count", 32'(count), 0);
    check("reset cell_id", 32'(cell_id), 0);
    check_stats("reset", 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("init%0d intense", i), 32'(intense), 1);
      check($sformatf("init%0d free_ready", i), 32'(ready), 0);
      check($sformatf("init%0d success", i), 32'(success), 0);
      check($sformatf("init%0d free_count", i), 32'(count), 32'(i));
      tick;
    end
    req = 1'b0;
    @(negedge clk);
    check("run intense", 32'(intense), 0);
    check("run free_count", 32'(count), 8);
    check("run free_ready full", 32'(ready), 0);
    check("run cell_id head", 32'(cell_id), 0);
    check_stats("post-init", 0, 0, 0, 8);
    // drain all cells then one refused request
    apply(0, 8);
    @(negedge clk);
    check_stats("drain", 8, 1, 0, 0);
    // simultaneous alloc+free, wrap, freed id reused
    apply(9, 20);
    @(negedge clk);
    check_stats("wrap", 10, 1, 0, 0);
    // oversize request leaves list untouched
    do_reset;
    repeat (8) tick;
    req = 1'b1; size = 16'd2049;
    @(negedge clk);
    check("oversize success", 32'(success), 0);
    tick;
    size = 16'd2048;
    @(negedge clk);
    check("oversize count kept", 32'(count), 8);
    check_stats("oversize", 0, 1, 0, 8);
    check("after oversize success", 32'(success), 1);
    check("after oversize id", 32'(cell_id), 0);
    tick;
    req = 1'b0;
    // free while full is refused and counted
    do_reset;
    repeat (8) tick;
    fv = 1'b1; fid = 16'd3;
    @(negedge clk);
    check("full free_ready", 32'(ready), 0);
    tick;
    fv = 1'b0;
    @(negedge clk);
    check("full count kept", 32'(count), 8);
    check_stats("free_err", 0, 0, 1, 8);
    // reset during INIT cycle 4 restarts the fill
    do_reset;
    repeat (3) tick;
    rst = 1'b1;
    @(negedge clk);
    check("mid-init count", 32'(count), 3);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("reinit%0d intense", i), 32'(intense), 1);
      check($sformatf("reinit%0d free_count", i), 32'(count), 32'(i));
      tick;
    end
    req = 1'b1; size = 16'd100;
    @(negedge clk);
    check("reinit success", 32'(success), 1);
    check("reinit first id", 32'(cell_id), 0);
    check("reinit intense", 32'(intense), 0);
    tick;
    req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
